// File: rtl/fa_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// fa_serial_add_ctrl_if
// Operand-request and result handshakes of the bit-serial adder sequencer.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source keeps valid and its payload
// steady until that edge. The request channel is offered by the requester.
// The result channel is offered by the sequencer.
//
// Signals:
//   req_valid / req_ready : request handshake
//   op_a, op_b, op_cin    : request payload (addends and initial carry)
//   res_valid / res_ready : result handshake
//   res_sum, res_cout     : result payload (WIDTH-bit sum and final carry)
// Modports:
//   master : requester / result consumer side
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface fa_serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  modport master (
    output req_valid, op_a, op_b, op_cin, res_ready,
    input  req_ready, res_valid, res_sum, res_cout
  );

  modport slave (
    input  req_valid, op_a, op_b, op_cin, res_ready,
    output req_ready, res_valid, res_sum, res_cout
  );
endinterface

// File: rtl/fa_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// fa_serial_add_ctrl
// Time-shares one external full-adder cell to add two WIDTH-bit operands
// bit-serially, starting at the LSB. Each bit is held on the cell pins for
// SETTLE+1 cycles. Sum and carry-out are sampled only on the last of those
// cycles. The carry-out is fed back to the cell's carry-in for the next bit.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : request/result valid-ready handshakes and payloads
//   abort              : cancels an add in progress (ignored outside RUN)
//   fa_a, fa_b, fa_cin : cell input pins, driven from flops only
//   fa_sum, fa_cout    : cell output pins
//   busy               : high while an add is in progress (RUN)
//   state_dbg          : current FSM state encoding (IDLE=0, RUN=1, DONE=2)
// ---------------------------------------------------------------------------
module fa_serial_add_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fa_serial_add_ctrl_if.slave   bus,
  input  logic                  abort,
  output logic                  fa_a,
  output logic                  fa_b,
  output logic                  fa_cin,
  input  logic                  fa_sum,
  input  logic                  fa_cout,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int BW = $clog2(WIDTH);
  // Keep the settle counter at least one bit wide, so that SETTLE=0 still works.
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;
  logic             carry_q;
  logic [BW-1:0]    bit_cnt;
  logic [SW-1:0]    set_cnt;

  logic             accept;
  logic             sample;
  logic             last_bit;
  logic [WIDTH-1:0] sum_next;

  assign accept   = (state_q == IDLE) && bus.req_valid;
  // abort takes priority, so an aborted final bit never completes.
  assign sample   = (state_q == RUN) && !abort && (set_cnt == SW'(SETTLE));
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));
  assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.res_valid = 1'b0;
    busy          = 1'b0;
    fa_a          = 1'b0;
    fa_b          = 1'b0;
    fa_cin        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        // State and operand flops gate the pins, so no input reaches fa_* combinationally.
        fa_a   = a_sr[0];
        fa_b   = b_sr[0];
        fa_cin = carry_q;
        if (abort) begin
          state_d = IDLE;
        end else if (sample && last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry recirculation, counters, result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      sum_sr     <= '0;
      carry_q    <= 1'b0;
      bit_cnt    <= '0;
      set_cnt    <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
    end else if (accept) begin
      a_sr    <= bus.op_a;
      b_sr    <= bus.op_b;
      carry_q <= bus.op_cin;
      sum_sr  <= '0;
      bit_cnt <= '0;
      set_cnt <= '0;
    end else if (sample) begin
      sum_sr  <= sum_next;
      carry_q <= fa_cout;
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      bit_cnt <= bit_cnt + 1'b1;
      set_cnt <= '0;
      if (last_bit) begin
        res_sum_q  <= sum_next;
        res_cout_q <= fa_cout;
      end
    end else if (state_q == RUN && !abort) begin
      set_cnt <= set_cnt + 1'b1;
    end
  end

  assign bus.res_sum  = res_sum_q;
  assign bus.res_cout = res_cout_q;
  assign state_dbg    = state_q;

endmodule
